keccak_padder: RTL

//  Downstream of size_counter in the SHAKE absorb path. Takes 64-bit message words plus the remaining bit count.

---
 rtl/keccak_padder_pkg.sv | 18 +
 rtl/keccak_padder_if.sv | 39 +++
 rtl/keccak_padder_pad_word_builder.sv | 33 +++
 rtl/keccak_padder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/keccak_padder_pkg.sv
// Shared constants and types for the Keccak pad10*1 padder.
package keccak_padder_pkg;

    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] PAD_FINAL    = 8'h80;

    localparam int unsigned RATE_WORDS_128 = 21;
    localparam int unsigned RATE_WORDS_256 = 17;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ABSORB   = 2'd1,
        PAD_HEAD = 2'd2,
        PAD_ZERO = 2'd3
    } pad_state_t;

endpackage

// File: rtl/keccak_padder_if.sv
// Message-in / padded-word-out bundle for keccak_padder.
// Optional macro KECCAK_PAD_DOMAIN_SEL_EN adds sha3_mode (domain byte select).
interface keccak_padder_if #(
    parameter int unsigned W         = 64,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic [CNT_WIDTH-1:0] remaining;
    logic [W-1:0]         in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 cnt_step;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_blk_end;
    logic                 out_msg_end;
    logic                 busy;
`ifdef KECCAK_PAD_DOMAIN_SEL_EN
    logic                 sha3_mode;
`endif

    modport master (
`ifdef KECCAK_PAD_DOMAIN_SEL_EN
        output sha3_mode,
`endif
        output start, remaining, in_data, in_valid, out_ready,
        input  in_ready, cnt_step, out_data, out_valid, out_blk_end, out_msg_end, busy
    );

    modport slave (
`ifdef KECCAK_PAD_DOMAIN_SEL_EN
        input  sha3_mode,
`endif
        input  start, remaining, in_data, in_valid, out_ready,
        output in_ready, cnt_step, out_data, out_valid, out_blk_end, out_msg_end, busy
    );

endinterface

// File: rtl/keccak_padder_pad_word_builder.sv
// Combinational builder for one padded word: keeps the first k bytes of data,
// places the domain byte at byte k, zeroes the rest, optionally ORs 0x80 into the top byte.
module keccak_padder_pad_word_builder
    import keccak_padder_pkg::*;
#(
    parameter int unsigned W  = 64,
    parameter int unsigned KW = 3
) (
    input  logic [W-1:0]  data,
    input  logic [KW-1:0] k,
    input  logic [7:0]    dom,
    input  logic          set_final,
    output logic [W-1:0]  word_c
);

    localparam int unsigned NB = W / 8;

    // Byte-wise keep / domain / zero selection, then the closing pad bit.
    always_comb begin
        word_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (KW'(i) < k) begin
                word_c[8*i +: 8] = data[8*i +: 8];
            end else if (KW'(i) == k) begin
                word_c[8*i +: 8] = dom;
            end
        end
        if (set_final) begin
            word_c[W-1 -: 8] = word_c[W-1 -: 8] | PAD_FINAL;
        end
    end

endmodule

// File: rtl/keccak_padder.sv
// Keccak pad10*1 padder: forwards message words, appends domain byte and
// zero fill up to the rate boundary, flags block and message ends.
// Optional macro KECCAK_PAD_DOMAIN_SEL_EN: sha3_mode sampled on start picks 0x06 vs 0x1F.
module keccak_padder
    import keccak_padder_pkg::*;
#(
    parameter int unsigned W          = 64,
    parameter int unsigned RATE_WORDS = RATE_WORDS_128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    keccak_padder_if.slave bus
);

    localparam int unsigned NB    = W / 8;
    localparam int unsigned KW    = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(RATE_WORDS);

    pad_state_t       state;
    pad_state_t       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     out_data_q;
    logic             out_valid_q;
    logic             out_blk_end_q;
    logic             out_msg_end_q;
    logic             cnt_step_q;
    logic             busy_q;

    logic             emit_ok;
    logic             drain;
    logic             last_slot;
    logic             rem_gt;
    logic             rem_eq;
    logic             load;
    logic             accept;
    logic             use_raw;
    logic             ld_msg_end;
    logic [W-1:0]     ld_data;
    logic [W-1:0]     b_data;
    logic [KW-1:0]    b_k;
    logic [7:0]       b_dom;
    logic             b_final;
    logic [W-1:0]     b_word;
    logic [7:0]       dom;

`ifdef KECCAK_PAD_DOMAIN_SEL_EN
    logic [7:0] dom_q;

    // Latch the domain byte at message start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dom_q <= DOMAIN_SHAKE;
        end else if (state == IDLE && bus.start) begin
            dom_q <= bus.sha3_mode ? DOMAIN_SHA3 : DOMAIN_SHAKE;
        end
    end

    assign dom = dom_q;
`else
    assign dom = DOMAIN_SHAKE;
`endif

    assign emit_ok   = !out_valid_q || bus.out_ready;
    assign drain     = out_valid_q && out_msg_end_q;
    assign last_slot = (idx == IDX_W'(RATE_WORDS - 1));
    assign rem_gt    = bus.remaining > CNT_WIDTH'(W);
    assign rem_eq    = bus.remaining == CNT_WIDTH'(W);

    assign bus.in_ready    = (state == ABSORB) && emit_ok;
    assign bus.cnt_step    = cnt_step_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_blk_end = out_blk_end_q;
    assign bus.out_msg_end = out_msg_end_q;
    assign bus.busy        = busy_q;

    keccak_padder_pad_word_builder #(
        .W  (W),
        .KW (KW)
    ) u_builder (
        .data      (b_data),
        .k         (b_k),
        .dom       (b_dom),
        .set_final (b_final),
        .word_c    (b_word)
    );

    assign ld_data = use_raw ? bus.in_data : b_word;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and word-load decision; the final word is held in PAD_ZERO until accepted.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        accept     = 1'b0;
        use_raw    = 1'b0;
        ld_msg_end = 1'b0;
        b_data     = '0;
        b_k        = '0;
        b_dom      = '0;
        b_final    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.remaining == '0) ? PAD_HEAD : ABSORB;
                end
            end
            ABSORB: begin
                if (bus.in_valid && emit_ok) begin
                    accept = 1'b1;
                    load   = 1'b1;
                    if (rem_gt) begin
                        use_raw = 1'b1;
                    end else if (rem_eq) begin
                        use_raw   = 1'b1;
                        state_nxt = PAD_HEAD;
                    end else begin
                        b_data     = bus.in_data;
                        b_k        = bus.remaining[KW+2:3];
                        b_dom      = dom;
                        b_final    = last_slot;
                        ld_msg_end = last_slot;
                        state_nxt  = PAD_ZERO;
                    end
                end
            end
            PAD_HEAD: begin
                if (emit_ok) begin
                    load       = 1'b1;
                    b_dom      = dom;
                    b_final    = last_slot;
                    ld_msg_end = last_slot;
                    state_nxt  = PAD_ZERO;
                end
            end
            PAD_ZERO: begin
                if (drain) begin
                    if (bus.out_ready) begin
                        state_nxt = IDLE;
                    end
                end else if (emit_ok) begin
                    load       = 1'b1;
                    b_final    = last_slot;
                    ld_msg_end = last_slot;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register, word index, step pulse and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_blk_end_q <= 1'b0;
            out_msg_end_q <= 1'b0;
            idx           <= '0;
            cnt_step_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cnt_step_q <= accept;
            busy_q     <= (state_nxt != IDLE);
            if (load) begin
                out_data_q    <= ld_data;
                out_valid_q   <= 1'b1;
                out_blk_end_q <= last_slot;
                out_msg_end_q <= ld_msg_end;
                idx           <= last_slot ? '0 : idx + IDX_W'(1);
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q   <= 1'b0;
                out_blk_end_q <= 1'b0;
                out_msg_end_q <= 1'b0;
            end
        end
    end

endmodule
